// File: rtl/scroll_strip.sv
// Horizontally scrolling 1-bit pattern strip with a registered pixel output.
// Optional speed ramp with play time is built when SCROLL_ACCEL_EN is defined.
module scroll_strip #(
    parameter int PAT_W        = 160,
    parameter int PAT_H        = 8,
    parameter int TOP_ROW      = 400,
    parameter int SPEED_INIT   = 6,
    parameter int SPEED_MAX    = 14,
    parameter int ACCEL_FRAMES = 600,
    localparam int ROW_W       = (PAT_H > 1) ? $clog2(PAT_H) : 1,
    localparam int POS_W       = $clog2(PAT_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       h_cnt,
    input  logic [9:0]       v_cnt,
    input  logic             vsync,
    input  logic [1:0]       state,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [PAT_W-1:0] wr_data,
    output logic             pixel_on,
    output logic [POS_W-1:0] position,
    output logic [4:0]       speed
);

    localparam int SUM_W = ((POS_W > 5) ? POS_W : 5) + 1;
    localparam logic [10:0] ROW_LO = 11'(TOP_ROW);
    localparam logic [10:0] ROW_HI = 11'(TOP_ROW + PAT_H);

    if (PAT_W < 2 || PAT_W > 512) begin : g_bad_w
        $error("scroll_strip: PAT_W out of range");
    end
    if (PAT_H < 1 || PAT_H > 64) begin : g_bad_h
        $error("scroll_strip: PAT_H out of range");
    end
    if (TOP_ROW + PAT_H > 480) begin : g_bad_top
        $error("scroll_strip: strip extends below visible area");
    end
    if (SPEED_INIT > SPEED_MAX || SPEED_MAX >= PAT_W || SPEED_MAX > 31) begin : g_bad_speed
        $error("scroll_strip: speed limits inconsistent");
    end
    if (ACCEL_FRAMES < 1) begin : g_bad_accel
        $error("scroll_strip: ACCEL_FRAMES must be at least 1");
    end

    // Exact reduction of h_cnt+position (at most 1534) into 0..PAT_W-1 by
    // restoring subtraction of PAT_W scaled by descending powers of two.
    function automatic logic [POS_W-1:0] wrap_col(input logic [10:0] val);
        logic [21:0] rem;
        rem = 22'(val);
        for (int s = 10; s >= 0; s--) begin
            if (rem >= (22'(PAT_W) << s)) begin
                rem = rem - (22'(PAT_W) << s);
            end
        end
        return rem[POS_W-1:0];
    endfunction

    logic             last_vsync;
    logic             tick;
    logic             running;
    logic             idle;
    logic [SUM_W-1:0] pos_sum;
    logic [POS_W-1:0] pos_next;

    assign tick    = vsync & ~last_vsync;
    assign running = (state == 2'b01) || (state == 2'b10);
    assign idle    = (state == 2'b00);

    // Single conditional subtract suffices because speed never reaches PAT_W.
    assign pos_sum  = SUM_W'(position) + SUM_W'(speed);
    assign pos_next = (pos_sum >= SUM_W'(PAT_W)) ? POS_W'(pos_sum - SUM_W'(PAT_W))
                                                 : POS_W'(pos_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_vsync <= 1'b0;
            position   <= '0;
        end else begin
            last_vsync <= vsync;
            if (tick && running) begin
                position <= pos_next;
            end
        end
    end

`ifdef SCROLL_ACCEL_EN
    localparam int FC_W = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(ACCEL_FRAMES - 1);

    logic [FC_W-1:0] frame_cnt;

    always_ff @(posedge clk) begin
        if (rst || idle) begin
            speed     <= 5'(SPEED_INIT);
            frame_cnt <= '0;
        end else if (tick && running) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt <= '0;
                if (speed < 5'(SPEED_MAX)) begin
                    speed <= speed + 5'd1;
                end
            end else begin
                frame_cnt <= frame_cnt + FC_W'(1);
            end
        end
    end
`else
    assign speed = 5'(SPEED_INIT);
`endif

    // Memory holds each row XORed with its power-up image (row 0 ones, rest
    // zero), so a cleared array reads back as the required start pattern.
    logic [PAT_W-1:0] pat_mem [PAT_H];

    always_ff @(posedge clk) begin
        if (wr_en && (32'(wr_row) < PAT_H)) begin
            pat_mem[wr_row] <= wr_data ^ ((wr_row == '0) ? {PAT_W{1'b1}} : {PAT_W{1'b0}});
        end
    end

    logic             in_strip;
    logic [ROW_W-1:0] row_idx;
    logic [POS_W-1:0] col_idx;
    logic [PAT_W-1:0] row_word;

    assign in_strip = ({1'b0, v_cnt} >= ROW_LO) && ({1'b0, v_cnt} < ROW_HI);
    assign row_idx  = ROW_W'(v_cnt - 10'(TOP_ROW));
    assign col_idx  = wrap_col(11'(h_cnt) + 11'(position));
    assign row_word = pat_mem[row_idx] ^ ((row_idx == '0) ? {PAT_W{1'b1}} : {PAT_W{1'b0}});

    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_on <= 1'b0;
        end else begin
            pixel_on <= in_strip & row_word[col_idx];
        end
    end

endmodule

// File: tb/tb_scroll_strip.sv
// Scoreboard bench for scroll_strip: driver pushes model predictions, monitor
// pops one per clock and compares pixel_on, position and speed.
module tb_scroll_strip;
`ifdef SCROLL_ACCEL_EN
    localparam int ACC  = 4;
    localparam int SMAX = 8;
`else
    localparam int ACC  = 600;
    localparam int SMAX = 14;
`endif
    localparam int W = 160, H = 8, TOP = 400, SINIT = 6;

    logic         clk = 0;
    logic         rst = 1;
    logic [9:0]   h_cnt = 0, v_cnt = 0;
    logic         vsync = 0;
    logic [1:0]   state = 0;
    logic         wr_en = 0;
    logic [2:0]   wr_row = 0;
    logic [W-1:0] wr_data = '0;
    logic         pixel_on;
    logic [7:0]   position;
    logic [4:0]   speed;

    always #5 clk = ~clk;

    scroll_strip #(.PAT_W(W), .PAT_H(H), .TOP_ROW(TOP), .SPEED_INIT(SINIT),
                   .SPEED_MAX(SMAX), .ACCEL_FRAMES(ACC)) dut (
        .clk(clk), .rst(rst), .h_cnt(h_cnt), .v_cnt(v_cnt), .vsync(vsync),
        .state(state), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
        .pixel_on(pixel_on), .position(position), .speed(speed));

    typedef struct { bit pix; int pos; int spd; } exp_t;
    exp_t q[$];
    int total = 0, bad = 0;

    int       m_pos = 0, m_speed = SINIT, m_fc = 0;
    bit       m_last = 0;
    bit [W-1:0] m_pat[H];
    bit       vs_r = 0;

    task automatic step(input bit r, input bit vs, input bit [1:0] st, input int h,
                        input int v, input bit we, input int wrow, input bit [W-1:0] wd);
        exp_t e;
        bit tk;
        @(negedge clk);
        rst = r; vsync = vs; state = st; h_cnt = 10'(h); v_cnt = 10'(v);
        wr_en = we; wr_row = 3'(wrow); wr_data = wd;
        e.pix = 0;
        if (r) begin
            m_pos = 0; m_speed = SINIT; m_fc = 0; m_last = 0;
        end else begin
            tk = vs && !m_last;
            m_last = vs;
            if (v >= TOP && v < TOP + H) e.pix = m_pat[v - TOP][(h + m_pos) % W];
            if (st == 2'b00) begin
                m_speed = SINIT; m_fc = 0;
            end else if (st != 2'b11 && tk) begin
                m_pos = (m_pos + m_speed) % W;
`ifdef SCROLL_ACCEL_EN
                m_fc = m_fc + 1;
                if (m_fc == ACC) begin
                    m_fc = 0;
                    if (m_speed < SMAX) m_speed = m_speed + 1;
                end
`endif
            end
        end
        if (we && wrow < H) m_pat[wrow] = wd;
        e.pos = m_pos; e.spd = m_speed;
        q.push_back(e);
    endtask

    task automatic idle_step(input bit r, input bit vs, input bit [1:0] st, input int h, input int v);
        step(r, vs, st, h, v, 0, 0, '0);
    endtask

    task automatic pulses(input int n, input bit [1:0] st);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 5; c++)
                idle_step(0, c < 2, st, $urandom_range(0, 1023), $urandom_range(396, 411));
        end
    endtask

    function automatic bit [W-1:0] rand_row();
        bit [W-1:0] d;
        for (int k = 0; k < W; k += 32) d[k +: 32] = $urandom;
        return d;
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (pixel_on !== e.pix) begin
                    bad++;
                    $display("FAIL pixel_on got=%0b want=%0b t=%0t", pixel_on, e.pix, $time);
                end
                total++;
                if (int'(position) != e.pos) begin
                    bad++;
                    $display("FAIL position got=%0d want=%0d t=%0t", position, e.pos, $time);
                end
                total++;
                if (int'(speed) != e.spd) begin
                    bad++;
                    $display("FAIL speed got=%0d want=%0d t=%0t", speed, e.spd, $time);
                end
            end
        end
    end

    initial begin : driver
        bit [W-1:0] d;
        for (int r = 0; r < H; r++) m_pat[r] = '0;
        m_pat[0] = '1;

        repeat (3) idle_step(1, 0, 2'b00, 0, 0);
        // Power-up pattern: row 0 lit everywhere, row 1 dark.
        for (int i = 0; i < 6; i++) idle_step(0, 0, 2'b00, $urandom_range(0, 1023), 400 + (i % 2));

        pulses(30, 2'b01);
        pulses(5, 2'b11);
        pulses(5, 2'b00);

        // Directed lookup on row 3 with position back at zero.
        repeat (2) idle_step(1, 0, 2'b00, 0, 0);
        d = '0; d[10] = 1'b1;
        step(0, 0, 2'b00, 0, 0, 1, 3, d);
        idle_step(0, 0, 2'b00, 10, 403);
        idle_step(0, 0, 2'b00, 170, 403);
        idle_step(0, 0, 2'b00, 11, 403);
        idle_step(0, 0, 2'b00, 10, 399);
        idle_step(0, 0, 2'b00, 10, 408);
        step(0, 0, 2'b00, 10, 403, 1, 3, '0);
        idle_step(0, 0, 2'b00, 10, 403);

        // vsync held high across reset release gives a single tick.
        repeat (3) idle_step(1, 1, 2'b01, 0, 0);
        for (int i = 0; i < 10; i++) idle_step(0, 1, 2'b01, $urandom_range(0, 1023), 400);
        idle_step(0, 0, 2'b01, 0, 0);

        // Speed ramp from reset.
        repeat (2) idle_step(1, 0, 2'b00, 0, 0);
        pulses(12, 2'b01);

        // Randomised mix of states, frame syncs, writes and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            bit [1:0] st;
            int sel;
            sel = $urandom_range(0, 9);
            st = (sel < 6) ? 2'(1 + (sel % 2)) : ((sel < 8) ? 2'b11 : 2'b00);
            if ($urandom_range(0, 3) == 0) vs_r = ~vs_r;
            if ($urandom_range(0, 15) == 0)
                step($urandom_range(0, 199) == 0, vs_r, st, $urandom_range(0, 1023),
                     $urandom_range(396, 411), 1, $urandom_range(0, H - 1), rand_row());
            else
                idle_step($urandom_range(0, 199) == 0, vs_r, st, $urandom_range(0, 1023),
                          $urandom_range(396, 411));
        end

        @(posedge clk);
        #3;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scroll_strip.md
# scroll_strip

Parametrised horizontally scrolling bitmap strip for the VGA game renderer, the generalised successor of the fixed ground layer. It stores a PAT_H-row by PAT_W-column 1-bit pattern, writable at run time, and scrolls it left once per frame while the game is running. Scroll speed can ramp with play time. One registered pixel bit is produced per clock for the pixel mixer, so ground, clouds and other strips can be instantiated from the same block.

## Interface
Parameters:
- PAT_W, 160: pattern width in columns, 2..512.
- PAT_H, 8: pattern height in rows, 1..64.
- TOP_ROW, 400: first screen line of the strip. TOP_ROW+PAT_H ≤ 480.
- SPEED_INIT, 6: pixels scrolled per frame after reset or idle.
- SPEED_MAX, 14: speed ceiling. SPEED_INIT ≤ SPEED_MAX < PAT_W.
- ACCEL_FRAMES, 600: running frames between speed increments (≥1).

Ports:
- clk, in, 1: pixel clock.
- rst, in, 1: reset, synchronous, active-high.
- h_cnt, in, 10: current pixel column.
- v_cnt, in, 10: current pixel line.
- vsync, in, 1: frame sync; each rising edge is one frame tick.
- state, in, 2: game state. 00 idle, 01/10 running, 11 game over.
- wr_en, in, 1: pattern row write strobe.
- wr_row, in, clog2(PAT_H) (min 1): row index for the write.
- wr_data, in, PAT_W: row bits. Bit i is column i.
- pixel_on, out, 1: registered strip pixel.
- position, out, clog2(PAT_W): current scroll offset.
- speed, out, 5: current pixels per frame.

## Operation
- Frame tick:
  - last_vsync is registered and resets to 0; tick = vsync & ~last_vsync.
  - vsync already high on the first cycle after reset produces a tick.
- Scroll on a tick with state 01/10:
  - position ← position+speed; subtract PAT_W once if the result ≥ PAT_W.
  - This is a single conditional subtract, valid because speed < PAT_W.
  - On any other cycle, or in state 00/11, position holds.
- Idle restart: while state==00, speed ← SPEED_INIT and the frame counter ← 0. position is not cleared.
- Game over (11): position, speed and the frame counter all freeze.
- Pixel lookup:
  - row = v_cnt−TOP_ROW; col = (h_cnt+position) mod PAT_W.
  - The modulo is exact for every h_cnt 0..1023; no approximation.
  - next = pattern[row][col] when TOP_ROW ≤ v_cnt < TOP_ROW+PAT_H, else 0.
- Pattern memory:
  - Not affected by rst.
  - Power-up contents: row 0 all ones, all other rows zero.
  - wr_en writes wr_data into row wr_row at the clock edge.
  - A write with wr_row ≥ PAT_H is ignored.
- Speed ramp: present only with SCROLL_ACCEL_EN; see Configuration.

## Timing
- Reset values: pixel_on=0, position=0, speed=SPEED_INIT, frame counter=0, last_vsync=0.
- pixel_on latency is 1 clock. The value registered at edge n reflects h_cnt, v_cnt, position and pattern sampled at edge n.
- A write at edge n is visible to the lookup from the cycle after edge n. The lookup at edge n reads the old row.
- A position update at edge n is seen by the lookup from cycle n+1.
- Tick and speed increment on the same edge: position advances by the old speed; the new speed applies from the next tick.
- Reset asserted mid-frame: all registers return to reset values on that edge. The pattern is kept.

## Configuration
- SCROLL_ACCEL_EN defined:
  - A frame counter 0..ACCEL_FRAMES−1 counts running ticks.
  - On the tick where it equals ACCEL_FRAMES−1, it wraps to 0 and speed ← min(speed+1, SPEED_MAX).
  - Speed saturates at SPEED_MAX; further wraps leave it unchanged.
- SCROLL_ACCEL_EN undefined:
  - No frame counter is built.
  - speed is the constant SPEED_INIT.

## Test plan
- Reset, state=01, 30 vsync pulses, defaults → position = 180 mod 160 = 20; speed=6 without the macro.
- state=11 then 00, 5 vsync pulses each → position unchanged. In state 00, speed returns to 6.
- Write row 3 = only bit 10 set, position=0, v_cnt=403:
  - h_cnt=10 → pixel_on=1 one clock later.
  - h_cnt=170 → 1, because 170 mod 160 = 10.
  - h_cnt=11 → 0.
  - v_cnt=399 or 408 → 0.
- wr_row=9 with PAT_H=8 → no row changes. Write at the same edge as a lookup of that row → old data on that lookup, new data on the next.
- With SCROLL_ACCEL_EN, ACCEL_FRAMES=4, SPEED_MAX=8, from reset:
  - Speed is 7 after tick 4 and 8 after tick 8, and stays 8 after tick 12.
  - Position after 8 ticks = 4·6+4·7 = 52.
- vsync held high across the reset release → exactly one tick is counted, not one per cycle.
